mem_port_arbiter: RTL

//  Sequences the single shared memory port between instruction fetch and data load/store requesters.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the shared memory port arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_moc;
   logic          d_req;
   logic          d_rw;
   logic [1:0]    d_type;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_moc;
   logic          d_err;
   logic          mem_en;
   logic          mem_rw;
   logic [1:0]    mem_type;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_rw, d_type, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_moc, d_rdata, d_moc, d_err,
             mem_en, mem_rw, mem_type, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_rw, d_type, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_moc, d_rdata, d_moc, d_err,
             mem_en, mem_rw, mem_type, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store with a wait-state counter.
// Optional macro MISALIGN_CHK_EN: misaligned data accesses complete immediately with d_err.
module mem_port_arbiter #(
   parameter int WAIT_CYCLES = 2,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic                 Clk,
   input  logic                 Clr,
   mem_port_arbiter_if.slave    bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, ACC = 2'b01, DONE = 2'b10} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          gnt_data_q, gnt_data_d;
   logic          last_data_q, last_data_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_rw_q, mem_rw_d;
   logic [1:0]    mem_type_q, mem_type_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          if_moc_q, if_moc_d;
   logic          d_moc_q, d_moc_d;
   logic          d_err_q, d_err_d;
   logic          pick_data_s;
   logic          misalign_s;

   // Data wins unless it won last time and fetch is waiting.
   assign pick_data_s = bus.d_req && !(last_data_q && bus.if_req);

`ifdef MISALIGN_CHK_EN
   assign misalign_s = ((bus.d_type == 2'b01) && bus.d_addr[0]) ||
                       (bus.d_type[1] && (bus.d_addr[1:0] != 2'b00));
`else
   assign misalign_s = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         gnt_data_q  <= 1'b0;
         last_data_q <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_type_q  <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_moc_q    <= 1'b0;
         d_moc_q     <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_data_q  <= gnt_data_d;
         last_data_q <= last_data_d;
         mem_en_q    <= mem_en_d;
         mem_rw_q    <= mem_rw_d;
         mem_type_q  <= mem_type_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_moc_q    <= if_moc_d;
         d_moc_q     <= d_moc_d;
         d_err_q     <= d_err_d;
      end
   end

   // Outputs are computed for the next state so every output is a flop.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_data_d  = gnt_data_q;
      last_data_d = last_data_q;
      mem_en_d    = 1'b0;
      mem_rw_d    = mem_rw_q;
      mem_type_d  = mem_type_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_moc_d    = 1'b0;
      d_moc_d     = 1'b0;
      d_err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.if_req || bus.d_req) begin
               gnt_data_d  = pick_data_s;
               last_data_d = pick_data_s;
               cnt_d       = WAIT_LD;
               if (pick_data_s) begin
                  mem_rw_d    = bus.d_rw;
                  mem_type_d  = (bus.d_type == 2'b11) ? 2'b10 : bus.d_type;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
               end else begin
                  mem_rw_d    = 1'b1;
                  mem_type_d  = 2'b10;
                  mem_addr_d  = bus.if_addr;
               end
               if (pick_data_s && misalign_s) begin
                  state_d = DONE;
                  d_moc_d = 1'b1;
                  d_err_d = 1'b1;
               end else begin
                  state_d  = ACC;
                  mem_en_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACC: begin
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               cnt_d   = 4'd0;
               if (mem_rw_q) begin
                  if (gnt_data_q) begin
                     d_rdata_d = bus.mem_rdata;
                  end else begin
                     if_rdata_d = bus.mem_rdata;
                  end
               end else begin
                  d_rdata_d = d_rdata_q;
               end
               if (gnt_data_q) begin
                  d_moc_d = 1'b1;
               end else begin
                  if_moc_d = 1'b1;
               end
            end else begin
               cnt_d    = cnt_q - 4'd1;
               mem_en_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_rw    = mem_rw_q;
   assign bus.mem_type  = mem_type_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_moc    = if_moc_q;
   assign bus.d_moc     = d_moc_q;
   assign bus.d_err     = d_err_q;
endmodule
